// File: rtl/ftq_meta_reader.sv
`default_nettype none
// ============================================================================
// Module   : ftq_meta_reader
// Purpose  : Read-side client for the FTQ meta SRAM (2^ADDR_W x DATA_W,
//            one-cycle read latency). Accepts FTQ-index read requests on a
//            valid/ready handshake, issues them to the SRAM read port and
//            collects the returned meta in a small in-order response buffer
//            that feeds the predictor-update path.
// Option   : `define FTQ_META_RD_BYPASS_EN to return the snooped write data
//            when a read and a write hit the same index in the same cycle.
//            Without it the snoop_* inputs are ignored.
// Ports    : clk, rst_n                 clock, async active-low reset
//            req_valid/req_ready/req_addr       read request channel
//            resp_valid/resp_ready/resp_data    response channel
//            sram_ren/sram_raddr/sram_rdata     SRAM read port
//            snoop_wen/snoop_waddr/snoop_wdata  copy of SRAM write port
// Revision : 1.0 - initial release
// ============================================================================
module ftq_meta_reader #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 256,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              sram_ren,
   output logic [ADDR_W-1:0] sram_raddr,
   input  logic [DATA_W-1:0] sram_rdata,
   input  logic              snoop_wen,
   input  logic [ADDR_W-1:0] snoop_waddr,
   input  logic [DATA_W-1:0] snoop_wdata
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [OCC_W:0]   C_DEPTH    = (OCC_W + 1)'(DEPTH);

   logic              inflight_v_q, inflight_v_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [DATA_W-1:0] buf_q [DEPTH];
   logic [DATA_W-1:0] buf_d [DEPTH];

   logic              w_req_fire;
   logic              w_pop;
   logic              w_push;
   logic [DATA_W-1:0] w_push_data;
   logic [OCC_W:0]    w_credit;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == C_PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Output handshakes
   assign resp_valid = (occ_q != '0);
   assign resp_data  = buf_q[head_q];
   assign w_pop      = resp_valid & resp_ready;

   // Credit: buffered + in-flight entries, less the one leaving this cycle,
   // must leave room for a new response. Extra MSB keeps the sum exact.
   assign w_credit   = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_v_q}
                     - {{OCC_W{1'b0}}, w_pop};
   assign req_ready  = rst_n & (w_credit < C_DEPTH);
   assign w_req_fire = req_valid & req_ready;

   assign sram_ren   = w_req_fire;
   assign sram_raddr = req_addr;

   // Read data returns one cycle after issue, aligned with inflight_v_q
   assign w_push     = inflight_v_q;

`ifdef FTQ_META_RD_BYPASS_EN
   logic              inflight_byp_q, inflight_byp_d;
   logic [DATA_W-1:0] inflight_bdata_q, inflight_bdata_d;

   // The SRAM returns old data on a same-cycle read/write collision, so the
   // write data is captured here and substituted when the read returns.
   always_comb begin
      inflight_byp_d   = w_req_fire & snoop_wen & (snoop_waddr == req_addr);
      inflight_bdata_d = inflight_bdata_q;
      if (inflight_byp_d) begin
         inflight_bdata_d = snoop_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_byp_q   <= 1'b0;
         inflight_bdata_q <= '0;
      end else begin
         inflight_byp_q   <= inflight_byp_d;
         inflight_bdata_q <= inflight_bdata_d;
      end
   end

   assign w_push_data = inflight_byp_q ? inflight_bdata_q : sram_rdata;
`else
   logic w_unused_snoop;
   assign w_unused_snoop = ^{snoop_wen, snoop_waddr, snoop_wdata};
   assign w_push_data    = sram_rdata;
`endif

   // Next-state for in-flight stage and response FIFO
   always_comb begin
      inflight_v_d = w_req_fire;
      head_d       = head_q;
      tail_d       = tail_q;
      occ_d        = occ_q;
      for (int i = 0; i < DEPTH; i++) begin
         buf_d[i] = buf_q[i];
      end

      if (w_push) begin
         buf_d[tail_q] = w_push_data;
         tail_d        = ptr_inc(tail_q);
      end
      if (w_pop) begin
         head_d = ptr_inc(head_q);
      end

      if (w_push && !w_pop) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (!w_push && w_pop) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_v_q <= 1'b0;
         occ_q        <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         inflight_v_q <= inflight_v_d;
         occ_q        <= occ_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= buf_d[i];
         end
      end
   end

endmodule
`default_nettype wire
